// File: rtl/pc_fetch_ctrl.sv
// Next-PC sequencing controller: owns the architectural PC, issues one
// instruction fetch at a time, presents it to execute, and retires it with
// either a redirect or PC+4. Flags misaligned targets and fetch timeouts.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_t;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] retired_q, retired_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  wcnt_q, wcnt_d;

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      retired_q  <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= 2'b00;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retired_q  <= retired_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      wcnt_q     <= wcnt_d;
    end
  end

  // Next-state and next-datapath values for the fetch/retire sequence.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retired_d  = retired_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    code_d     = code_q;
    wcnt_d     = wcnt_q;

    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = S_VALID;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          code_d  = 2'b10;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_VALID: begin
        if (!stall) begin
          retired_d = retired_q + 32'd1;
          valid_d   = 1'b0;
          if (redirect_en && (redirect_target[1:0] != 2'b00)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
            code_d  = 2'b01;
          end else if (redirect_en) begin
            pc_d    = redirect_target;
            state_d = S_REQ;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // imem_req is a flop that anticipates entry into REQ, so it is glitch-free
    // yet asserted exactly during REQ cycles.
    req_d = (state_d == S_REQ);
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign retired_cnt = retired_q;

endmodule
